// File: rtl/welford_pkg.sv
// Shared types and width helpers for the Welford flow-state export path.
package welford_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4,
        ST_CLEAR   = 3'd5
    } state_t;

    localparam int INDEX_WIDTH_DEF     = 10;
    localparam int RAM_LATENCY_DEF     = 2;
    localparam int SCALING_DEF         = 32;
    localparam int DATAIN_WIDTH_DEF    = 11;
    localparam int RES_SHORT_WIDTH_DEF = 24;
    localparam int RES_LONG_WIDTH_DEF  = 40;

    function automatic int delta_scaling(input int datain_width);
        return 18 - datain_width - 1;
    endfunction

    function automatic int mean_width(input int datain_width, input int scaling);
        return datain_width + scaling;
    endfunction

    function automatic int m2_in_width(input int res_long_width, input int delta);
        return res_long_width + 2 * delta + 1;
    endfunction

    function automatic int output_width(input int res_short_width, input int res_long_width);
        return 3 * res_short_width + res_long_width;
    endfunction

    function automatic int table_last(input int index_width);
        return (1 << index_width) - 1;
    endfunction

endpackage

// File: rtl/concatenate.sv
// Packs one Welford entry into an export tuple: {syn_count, pkt_count, mean int, m2 window}.
module concatenate #(
    parameter int SCALING         = 32,
    parameter int DATAIN_WIDTH    = 11,
    parameter int RES_SHORT_WIDTH = 24,
    parameter int RES_LONG_WIDTH  = 40,
    parameter int DELTA_SCALING   = 6,
    localparam int MEAN_WIDTH     = DATAIN_WIDTH + SCALING,
    localparam int M2_IN_WIDTH    = RES_LONG_WIDTH + 2 * DELTA_SCALING + 1,
    localparam int OUTPUT_WIDTH   = 3 * RES_SHORT_WIDTH + RES_LONG_WIDTH
) (
    input  logic [RES_SHORT_WIDTH-1:0] syn_count,
    input  logic [RES_SHORT_WIDTH-1:0] pkt_count,
    input  logic [MEAN_WIDTH-1:0]      mean,
    input  logic [M2_IN_WIDTH-1:0]     m2,
    output logic [OUTPUT_WIDTH-1:0]    tuple_data
);

    // Fractional mean, m2 sign and the extra m2 scaling bits are dropped from the tuple.
    logic unused_bits;
    assign unused_bits = ^{mean[SCALING-1:0], m2[M2_IN_WIDTH-1], m2[2*DELTA_SCALING-1:0]};

    assign tuple_data = {syn_count,
                         pkt_count,
                         {(RES_SHORT_WIDTH-DATAIN_WIDTH){1'b0}}, mean[MEAN_WIDTH-1:SCALING],
                         m2[RES_LONG_WIDTH+2*DELTA_SCALING-1:2*DELTA_SCALING]};

endmodule

// File: rtl/welford_export_ctrl.sv
// Reads flow entries for eviction or table dump, exports them as tuples, clears evicted entries.
//   state   | meaning
//   IDLE    | arbitrate: eviction first, then next scan entry
//   READ    | ram_rd_en for the selected index
//   WAIT    | down-counter covers remaining RAM latency
//   CAPTURE | register the four RAM fields
//   OUT     | tuple_valid held until tuple_ready
//   CLEAR   | ram_clr_en on the evicted index
module welford_export_ctrl
    import welford_pkg::*;
#(
    parameter int INDEX_WIDTH     = INDEX_WIDTH_DEF,
    parameter int RAM_LATENCY     = RAM_LATENCY_DEF,
    parameter int SCALING         = SCALING_DEF,
    parameter int DATAIN_WIDTH    = DATAIN_WIDTH_DEF,
    parameter int RES_SHORT_WIDTH = RES_SHORT_WIDTH_DEF,
    parameter int RES_LONG_WIDTH  = RES_LONG_WIDTH_DEF,
    localparam int DELTA_SCALING  = delta_scaling(DATAIN_WIDTH),
    localparam int MEAN_WIDTH     = mean_width(DATAIN_WIDTH, SCALING),
    localparam int M2_IN_WIDTH    = m2_in_width(RES_LONG_WIDTH, DELTA_SCALING),
    localparam int OUTPUT_WIDTH   = output_width(RES_SHORT_WIDTH, RES_LONG_WIDTH)
) (
    input  logic                       clk_lookup,
    input  logic                       resetn,
    input  logic                       evict_req_valid,
    input  logic [INDEX_WIDTH-1:0]     evict_req_index,
    output logic                       evict_req_ready,
    input  logic                       dump_start,
    output logic                       dump_busy,
    output logic                       dump_done,
    output logic                       ram_rd_en,
    output logic [INDEX_WIDTH-1:0]     ram_rd_addr,
    input  logic [RES_SHORT_WIDTH-1:0] ram_rd_syn_count,
    input  logic [RES_SHORT_WIDTH-1:0] ram_rd_pkt_count,
    input  logic [MEAN_WIDTH-1:0]      ram_rd_mean,
    input  logic [M2_IN_WIDTH-1:0]     ram_rd_m2,
    output logic                       ram_clr_en,
    output logic [INDEX_WIDTH-1:0]     ram_clr_addr,
    output logic                       tuple_valid,
    output logic [OUTPUT_WIDTH-1:0]    tuple_data,
    output logic [INDEX_WIDTH-1:0]     tuple_index,
    output logic                       tuple_is_evict,
    input  logic                       tuple_ready
);

    localparam int TABLE_LAST = table_last(INDEX_WIDTH);
    localparam int CNT_WIDTH  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    state_t                     state, state_nxt;
    logic                       run;
    logic [INDEX_WIDTH-1:0]     cur_index;
    logic                       cur_is_evict;
    logic [INDEX_WIDTH-1:0]     scan_ptr;
    logic [CNT_WIDTH-1:0]       wait_cnt;
    logic [RES_SHORT_WIDTH-1:0] cap_syn_count;
    logic [RES_SHORT_WIDTH-1:0] cap_pkt_count;
    logic [MEAN_WIDTH-1:0]      cap_mean;
    logic [M2_IN_WIDTH-1:0]     cap_m2;
    logic                       evict_accept;
    logic                       scan_issue;
    logic                       scan_handshake;

    always_comb begin
        state_nxt    = state;
        evict_accept = 1'b0;
        scan_issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && evict_req_valid) begin
                    evict_accept = 1'b1;
                    state_nxt    = ST_READ;
                end else if (dump_busy) begin
                    scan_issue = 1'b1;
                    state_nxt  = ST_READ;
                end
            end
            ST_READ:    state_nxt = (RAM_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    if (wait_cnt == CNT_WIDTH'(1)) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_OUT;
            ST_OUT:     if (tuple_ready) state_nxt = cur_is_evict ? ST_CLEAR : ST_IDLE;
            ST_CLEAR:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign scan_handshake = (state == ST_OUT) && tuple_ready && !cur_is_evict;

    // run keeps evict_req_ready low while reset is asserted even though state is IDLE.
    always_ff @(posedge clk_lookup or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            run           <= 1'b0;
            cur_index     <= '0;
            cur_is_evict  <= 1'b0;
            scan_ptr      <= '0;
            dump_busy     <= 1'b0;
            wait_cnt      <= '0;
            cap_syn_count <= '0;
            cap_pkt_count <= '0;
            cap_mean      <= '0;
            cap_m2        <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (evict_accept) begin
                cur_index    <= evict_req_index;
                cur_is_evict <= 1'b1;
            end else if (scan_issue) begin
                cur_index    <= scan_ptr;
                cur_is_evict <= 1'b0;
            end
            if (state == ST_READ) begin
                wait_cnt <= CNT_WIDTH'(RAM_LATENCY - 1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == ST_CAPTURE) begin
                cap_syn_count <= ram_rd_syn_count;
                cap_pkt_count <= ram_rd_pkt_count;
                cap_mean      <= ram_rd_mean;
                cap_m2        <= ram_rd_m2;
            end
            // A start that coincides with an eviction accept is held in dump_busy and served after it.
            if (dump_start && !dump_busy && state == ST_IDLE) begin
                dump_busy <= 1'b1;
                scan_ptr  <= '0;
            end else if (scan_handshake) begin
                scan_ptr <= scan_ptr + 1'b1;
                if (cur_index == INDEX_WIDTH'(TABLE_LAST)) dump_busy <= 1'b0;
            end
        end
    end

    assign evict_req_ready = run && (state == ST_IDLE);
    assign dump_done       = scan_handshake && (cur_index == INDEX_WIDTH'(TABLE_LAST));
    assign ram_rd_en       = (state == ST_READ);
    assign ram_rd_addr     = cur_index;
    assign ram_clr_en      = (state == ST_CLEAR);
    assign ram_clr_addr    = cur_index;
    assign tuple_valid     = (state == ST_OUT);
    assign tuple_index     = cur_index;
    assign tuple_is_evict  = cur_is_evict;

    concatenate #(
        .SCALING         (SCALING),
        .DATAIN_WIDTH    (DATAIN_WIDTH),
        .RES_SHORT_WIDTH (RES_SHORT_WIDTH),
        .RES_LONG_WIDTH  (RES_LONG_WIDTH),
        .DELTA_SCALING   (DELTA_SCALING)
    ) u_concatenate (
        .syn_count  (cap_syn_count),
        .pkt_count  (cap_pkt_count),
        .mean       (cap_mean),
        .m2         (cap_m2),
        .tuple_data (tuple_data)
    );

endmodule

// File: tb/tb_welford_export_ctrl.sv
// Directed bench for welford_export_ctrl with an 8-entry table and a scoreboard of expected tuples.
module tb_welford_export_ctrl;

    localparam int IW = 3;
    localparam int N  = 8;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          ev;
        logic          done;
        logic [111:0]  data;
    } exp_t;

    logic          clk_lookup = 1'b0;
    logic          resetn;
    logic          evict_req_valid;
    logic [IW-1:0] evict_req_index;
    logic          evict_req_ready;
    logic          dump_start;
    logic          dump_busy;
    logic          dump_done;
    logic          ram_rd_en;
    logic [IW-1:0] ram_rd_addr;
    logic [23:0]   ram_rd_syn_count;
    logic [23:0]   ram_rd_pkt_count;
    logic [42:0]   ram_rd_mean;
    logic [52:0]   ram_rd_m2;
    logic          ram_clr_en;
    logic [IW-1:0] ram_clr_addr;
    logic          tuple_valid;
    logic [111:0]  tuple_data;
    logic [IW-1:0] tuple_index;
    logic          tuple_is_evict;
    logic          tuple_ready;

    int n_cmp = 0;
    int n_err = 0;

    exp_t          exp_q[$];
    logic [IW-1:0] clr_q[$];

    logic [23:0] ref_syn[N];
    logic [23:0] ref_pkt[N];
    logic [42:0] ref_mean[N];
    logic [52:0] ref_m2[N];

    logic [23:0] mem_syn[N];
    logic [23:0] mem_pkt[N];
    logic [42:0] mem_mean[N];
    logic [52:0] mem_m2[N];
    logic        mem_init;
    logic [IW-1:0] a0, a1;

    always #5 clk_lookup = ~clk_lookup;

    welford_export_ctrl #(
        .INDEX_WIDTH (IW),
        .RAM_LATENCY (2)
    ) dut (
        .clk_lookup       (clk_lookup),
        .resetn           (resetn),
        .evict_req_valid  (evict_req_valid),
        .evict_req_index  (evict_req_index),
        .evict_req_ready  (evict_req_ready),
        .dump_start       (dump_start),
        .dump_busy        (dump_busy),
        .dump_done        (dump_done),
        .ram_rd_en        (ram_rd_en),
        .ram_rd_addr      (ram_rd_addr),
        .ram_rd_syn_count (ram_rd_syn_count),
        .ram_rd_pkt_count (ram_rd_pkt_count),
        .ram_rd_mean      (ram_rd_mean),
        .ram_rd_m2        (ram_rd_m2),
        .ram_clr_en       (ram_clr_en),
        .ram_clr_addr     (ram_clr_addr),
        .tuple_valid      (tuple_valid),
        .tuple_data       (tuple_data),
        .tuple_index      (tuple_index),
        .tuple_is_evict   (tuple_is_evict),
        .tuple_ready      (tuple_ready)
    );

    function automatic logic [23:0] init_syn(input int i);
        return (i == 5) ? 24'd3 : 24'(i * 7 + 1);
    endfunction

    function automatic logic [23:0] init_pkt(input int i);
        return (i == 5) ? 24'd100 : 24'(i * 1000 + 11);
    endfunction

    function automatic logic [42:0] init_mean(input int i);
        return (i == 5) ? {11'd700, 32'hABCD1234} : {11'(100 + i * 37), 32'(i * 32'h01234567 + 9)};
    endfunction

    function automatic logic [52:0] init_m2(input int i);
        return (i == 5) ? {1'b0, 40'h1000, 12'h5A5}
                        : {1'(i % 2), 40'(i) * 40'h11_0000_0003 + 40'd7, 12'(i * 291 + 5)};
    endfunction

    function automatic logic [111:0] model(input int i);
        return {ref_syn[i], ref_pkt[i], 13'd0, ref_mean[i][42:32], ref_m2[i][51:12]};
    endfunction

    // RAM: two-cycle read latency, clear strobe zeroes an entry.
    always @(posedge clk_lookup) begin
        a0 <= ram_rd_addr;
        a1 <= a0;
        if (mem_init) begin
            for (int i = 0; i < N; i++) begin
                mem_syn[i]  <= init_syn(i);
                mem_pkt[i]  <= init_pkt(i);
                mem_mean[i] <= init_mean(i);
                mem_m2[i]   <= init_m2(i);
            end
        end else if (ram_clr_en) begin
            mem_syn[ram_clr_addr]  <= '0;
            mem_pkt[ram_clr_addr]  <= '0;
            mem_mean[ram_clr_addr] <= '0;
            mem_m2[ram_clr_addr]   <= '0;
        end
    end

    assign ram_rd_syn_count = mem_syn[a1];
    assign ram_rd_pkt_count = mem_pkt[a1];
    assign ram_rd_mean      = mem_mean[a1];
    assign ram_rd_m2        = mem_m2[a1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_lookup);
        #1;
    endtask

    task automatic push_scan(input int i);
        exp_t e;
        e.idx  = IW'(i);
        e.ev   = 1'b0;
        e.done = (i == N - 1);
        e.data = model(i);
        exp_q.push_back(e);
    endtask

    task automatic push_evict(input int i);
        exp_t e;
        e.idx  = IW'(i);
        e.ev   = 1'b1;
        e.done = 1'b0;
        e.data = model(i);
        exp_q.push_back(e);
        clr_q.push_back(IW'(i));
        ref_syn[i]  = '0;
        ref_pkt[i]  = '0;
        ref_mean[i] = '0;
        ref_m2[i]   = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic drained;
        drained = 1'b0;
        for (int c = 0; c < budget && !drained; c++) begin
            tick();
            drained = (exp_q.size() == 0) && (clr_q.size() == 0) && !dump_busy && evict_req_ready;
        end
        chk(tag, drained, 1'b1);
    endtask

    // Scoreboard: tuple handshakes and clear strobes, sampled mid-cycle.
    logic          stall_prev = 1'b0;
    logic [111:0]  held_data;
    logic [IW-1:0] held_index;
    logic          held_ev;

    always @(negedge clk_lookup) begin
        if (resetn) begin
            if (stall_prev && tuple_valid) begin
                chk("hold_data", tuple_data, held_data);
                chk("hold_index", tuple_index, held_index);
                chk("hold_evict", tuple_is_evict, held_ev);
            end
            if (tuple_valid) chk("ready_while_out", evict_req_ready, 1'b0);
            if (tuple_valid && tuple_ready) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL tuple_extra: index %0d observed, nothing expected", tuple_index);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tuple_index", tuple_index, e.idx);
                    chk("tuple_is_evict", tuple_is_evict, e.ev);
                    chk("tuple_data", tuple_data, e.data);
                    chk("dump_done_hs", dump_done, e.done);
                end
            end else begin
                chk("dump_done_idle", dump_done, 1'b0);
            end
            if (ram_clr_en) begin
                n_cmp++;
                assert (clr_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL clear_extra: addr %0d observed, nothing expected", ram_clr_addr);
                end
                if (clr_q.size() != 0) chk("clear_addr", ram_clr_addr, clr_q.pop_front());
            end
            stall_prev = tuple_valid && !tuple_ready;
            held_data  = tuple_data;
            held_index = tuple_index;
            held_ev    = tuple_is_evict;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [111:0] exp3;
        logic         seen;

        resetn          = 1'b0;
        evict_req_valid = 1'b0;
        evict_req_index = '0;
        dump_start      = 1'b0;
        tuple_ready     = 1'b1;
        mem_init        = 1'b1;
        for (int i = 0; i < N; i++) begin
            ref_syn[i]  = init_syn(i);
            ref_pkt[i]  = init_pkt(i);
            ref_mean[i] = init_mean(i);
            ref_m2[i]   = init_m2(i);
        end
        tick();
        tick();
        mem_init = 1'b0;

        // Reset values
        chk("rst_evict_ready", evict_req_ready, 1'b0);
        chk("rst_dump_busy", dump_busy, 1'b0);
        chk("rst_rd_en", ram_rd_en, 1'b0);
        chk("rst_clr_en", ram_clr_en, 1'b0);
        chk("rst_tuple_valid", tuple_valid, 1'b0);
        chk("rst_tuple_data", tuple_data, 112'd0);
        chk("rst_tuple_index", tuple_index, 3'd0);
        resetn = 1'b1;
        tick();
        tick();

        // Single eviction of entry 5, latency check cycle by cycle
        chk("evict_ready_idle", evict_req_ready, 1'b1);
        evict_req_valid = 1'b1;
        evict_req_index = 3'd5;
        push_evict(5);
        tick();
        evict_req_valid = 1'b0;
        chk("t1_rd_en", ram_rd_en, 1'b1);
        chk("t1_rd_addr", ram_rd_addr, 3'd5);
        tick();
        chk("t2_valid", tuple_valid, 1'b0);
        tick();
        chk("t3_valid", tuple_valid, 1'b0);
        tick();
        chk("t4_valid", tuple_valid, 1'b1);
        chk("t4_data_const", tuple_data, {24'd3, 24'd100, 24'd700, 40'h1000});
        chk("t4_is_evict", tuple_is_evict, 1'b1);
        tick();
        chk("t5_clr_en", ram_clr_en, 1'b1);
        chk("t5_clr_addr", ram_clr_addr, 3'd5);
        chk("t5_not_ready", evict_req_ready, 1'b0);
        tick();
        chk("t6_ready", evict_req_ready, 1'b1);
        chk("t6_clr_off", ram_clr_en, 1'b0);

        // Backpressure on an eviction of entry 3
        tuple_ready     = 1'b0;
        exp3            = model(3);
        evict_req_valid = 1'b1;
        evict_req_index = 3'd3;
        push_evict(3);
        tick();
        evict_req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = tuple_valid;
        end
        chk("bp_valid_seen", seen, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", tuple_valid, 1'b1);
            chk("bp_data", tuple_data, exp3);
            chk("bp_index", tuple_index, 3'd3);
        end
        tuple_ready = 1'b1;
        tick();
        chk("bp_clr_en", ram_clr_en, 1'b1);
        chk("bp_clr_addr", ram_clr_addr, 3'd3);
        tick();
        chk("bp_ready_again", evict_req_ready, 1'b1);

        // Full scan 0..7
        for (int i = 0; i < N; i++) push_scan(i);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("scan_busy", dump_busy, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            seen = dump_done;
        end
        chk("scan_done_seen", seen, 1'b1);
        chk("scan_done_index", tuple_index, 3'd7);
        tick();
        chk("scan_busy_fall", dump_busy, 1'b0);
        chk("scan_ready_after", evict_req_ready, 1'b1);
        chk("scan_q_empty", exp_q.size(), 0);

        // Pre-emption at index 4 and an ignored mid-scan dump_start
        for (int i = 0; i <= 4; i++) push_scan(i);
        push_evict(2);
        for (int i = 5; i < N; i++) push_scan(i);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            seen = ram_rd_en && (ram_rd_addr == 3'd4);
        end
        chk("pre_read4_seen", seen, 1'b1);
        evict_req_valid = 1'b1;
        evict_req_index = 3'd2;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (evict_req_ready) seen = 1'b1;
            else tick();
        end
        chk("pre_evict_accepted", seen, 1'b1);
        tick();
        evict_req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            seen = tuple_valid && !tuple_is_evict && (tuple_index == 3'd5);
        end
        chk("pre_tuple5_seen", seen, 1'b1);
        tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_drain("pre_drain", 300);

        // Simultaneous dump_start and eviction of entry 6
        push_evict(6);
        for (int i = 0; i < N; i++) push_scan(i);
        chk("sim_ready", evict_req_ready, 1'b1);
        dump_start      = 1'b1;
        evict_req_valid = 1'b1;
        evict_req_index = 3'd6;
        tick();
        dump_start      = 1'b0;
        evict_req_valid = 1'b0;
        chk("sim_busy", dump_busy, 1'b1);
        wait_drain("sim_drain", 300);

        // Reset during WAIT of a scan, then restart from index 0
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = ram_rd_en;
        end
        chk("rst_scan_read_seen", seen, 1'b1);
        tick();
        resetn = 1'b0;
        #1;
        chk("midrst_busy", dump_busy, 1'b0);
        chk("midrst_done", dump_done, 1'b0);
        chk("midrst_valid", tuple_valid, 1'b0);
        chk("midrst_rd_en", ram_rd_en, 1'b0);
        chk("midrst_rd_addr", ram_rd_addr, 3'd0);
        chk("midrst_ready", evict_req_ready, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();
        for (int i = 0; i < N; i++) push_scan(i);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_drain("restart_drain", 300);

        chk("final_tuple_q", exp_q.size(), 0);
        chk("final_clear_q", clr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
